// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith ops, iterative
// shift-add MUL and restoring DIV, registered result and flags.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WL = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_ASR = 4'hA;
    localparam logic [3:0] OP_SLT = 4'hB;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] y_q, y_hi_q;
    logic             zero_q, carry_q, overflow_q, dbz_q;
    logic             is_mul_q;
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [SHW-1:0]   cnt_q;

    logic [WIDTH:0]   add_s, sub_s;
    logic [WIDTH-1:0] s_y, s_hi;
    logic             s_c, s_v, s_dz;

    assign add_s = {1'b0, a} + {1'b0, b};
    assign sub_s = {1'b0, a} - {1'b0, b};

    always_comb begin
        s_y  = '0;
        s_hi = '0;
        s_c  = 1'b0;
        s_v  = 1'b0;
        s_dz = 1'b0;
        case (opcode)
            OP_ADD: begin
                s_y = add_s[WIDTH-1:0];
                s_c = add_s[WIDTH];
                s_v = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_y = sub_s[WIDTH-1:0];
                s_c = sub_s[WIDTH];
                s_v = (a[WIDTH-1] != b[WIDTH-1]) &&
                      (sub_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_DIV: begin
                // only reached here with b == 0; nonzero divisors iterate
                s_y  = '1;
                s_hi = a;
                s_dz = 1'b1;
            end
            OP_AND: s_y = a & b;
            OP_OR:  s_y = a | b;
            OP_XOR: s_y = a ^ b;
            OP_NOT: s_y = ~a;
            OP_SHL: s_y = (b < WL) ? (a << b) : '0;
            OP_SHR: s_y = (b < WL) ? (a >> b) : '0;
            OP_ASR: s_y = (b < WL) ? WIDTH'($signed(a) >>> b)
                                   : {WIDTH{a[WIDTH-1]}};
            OP_SLT: s_y = WIDTH'($signed(a) < $signed(b));
            default: s_y = '0;
        endcase
    end

    // one shift-add step: partial product {hi_q, lo_q}, multiplier in lo_q
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};

    // one restoring step: remainder in hi_q, dividend/quotient in lo_q
    logic [WIDTH:0]   div_sh, div_tr;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem_n, div_q_n;
    assign div_sh    = {hi_q, lo_q[WIDTH-1]};
    assign div_tr    = div_sh - {1'b0, b_q};
    assign div_ok    = !div_tr[WIDTH];
    assign div_rem_n = div_ok ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_q_n   = {lo_q[WIDTH-2:0], div_ok};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_hi_q      <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
            is_mul_q    <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    if (opcode == OP_MUL ||
                        (opcode == OP_DIV && b != '0)) begin
                        state_q  <= BUSY;
                        is_mul_q <= (opcode == OP_MUL);
                        hi_q     <= '0;
                        lo_q     <= a;
                        b_q      <= b;
                        cnt_q    <= CNT_INIT;
                    end else begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        y_q         <= s_y;
                        y_hi_q      <= s_hi;
                        zero_q      <= (s_y == '0);
                        carry_q     <= s_c;
                        overflow_q  <= s_v;
                        dbz_q       <= s_dz;
                    end
                end
                BUSY: begin
                    hi_q  <= is_mul_q ? mul_hi_n : div_rem_n;
                    lo_q  <= is_mul_q ? mul_lo_n : div_q_n;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        y_q         <= is_mul_q ? mul_lo_n : div_q_n;
                        y_hi_q      <= is_mul_q ? mul_hi_n : div_rem_n;
                        zero_q      <= is_mul_q ? (mul_lo_n == '0)
                                                : (div_q_n == '0);
                        carry_q     <= 1'b0;
                        overflow_q  <= is_mul_q && (mul_hi_n != '0);
                        dbz_q       <= 1'b0;
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign y           = y_q;
    assign y_hi        = y_hi_q;
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed and random ops against an
// arithmetic reference model, plus backpressure and reset-abort cases.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] opcode;
    logic [7:0] a, b, y, y_hi;
    logic       zero, carry, overflow, div_by_zero;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_hi(y_hi), .zero(zero), .carry(carry),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: plain integer arithmetic on the operation definitions
    task automatic model(input int op, input int av, input int bv,
                         output int ey, output int ehi, output int ez,
                         output int ec, output int ev, output int edz,
                         output int elat);
        int sa, sb, r;
        sa = (av > 127) ? av - 256 : av;
        sb = (bv > 127) ? bv - 256 : bv;
        ey = 0; ehi = 0; ec = 0; ev = 0; edz = 0; elat = 1;
        case (op)
            0: begin
                ey = (av + bv) % 256; ec = (av + bv > 255);
                r = sa + sb; ev = (r > 127 || r < -128);
            end
            1: begin
                ey = (av - bv + 256) % 256; ec = (av < bv);
                r = sa - sb; ev = (r > 127 || r < -128);
            end
            2: begin
                ey = (av * bv) % 256; ehi = (av * bv) / 256;
                ev = (ehi != 0); elat = 9;
            end
            3: if (bv == 0) begin
                ey = 255; ehi = av; edz = 1;
            end else begin
                ey = av / bv; ehi = av % bv; elat = 9;
            end
            4: ey = av & bv;
            5: ey = av | bv;
            6: ey = av ^ bv;
            7: ey = 255 - av;
            8: ey = (bv >= 8) ? 0 : (av * (1 << bv)) % 256;
            9: ey = (bv >= 8) ? 0 : av / (1 << bv);
            10: ey = (bv >= 8) ? ((sa < 0) ? 255 : 0)
                               : ((sa >>> bv) + 256) % 256;
            11: ey = (sa < sb) ? 1 : 0;
            default: ey = 0;
        endcase
        ez = (ey == 0);
    endtask

    task automatic do_op(input int op, input int av, input int bv,
                         input int hold);
        int ey, ehi, ez, ec, ev, edz, elat, lat;
        logic busy_ok, hold_ok;
        logic [7:0] ys;
        model(op, av, bv, ey, ehi, ez, ec, ev, edz, elat);
        @(negedge clk);
        opcode = 4'(op); a = 8'(av); b = 8'(bv); in_valid = 1'b1;
        chk("in_ready_idle", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = 1; busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("lat op%0h", op), lat, elat);
        chk("busy_in_ready", {31'b0, busy_ok}, 1);
        chk($sformatf("y op%0h %0h,%0h", op, av, bv), {24'b0, y}, ey);
        chk($sformatf("y_hi op%0h", op), {24'b0, y_hi}, ehi);
        chk($sformatf("zero op%0h", op), {31'b0, zero}, ez);
        chk($sformatf("carry op%0h", op), {31'b0, carry}, ec);
        chk($sformatf("ovf op%0h", op), {31'b0, overflow}, ev);
        chk($sformatf("dbz op%0h", op), {31'b0, div_by_zero}, edz);
        ys = y; hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== ys)
                hold_ok = 1'b0;
        end
        if (hold > 0) chk("hold_stable", {31'b0, hold_ok}, 1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", {31'b0, out_valid}, 0);
        chk("release_ready", {31'b0, in_ready}, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        opcode = 4'h0; a = 8'h03; b = 8'h04;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", {31'b0, out_valid}, 0);
        chk("rst in_ready", {31'b0, in_ready}, 1);
        chk("rst y", {24'b0, y}, 0);
        chk("rst y_hi", {24'b0, y_hi}, 0);
        chk("rst flags", {28'b0, zero, carry, overflow, div_by_zero}, 0);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;

        do_op(0, 8'h7F, 8'h01, 0);
        do_op(1, 8'h00, 8'h01, 0);
        do_op(0, 8'hFF, 8'h01, 0);
        do_op(2, 8'h10, 8'h20, 0);
        do_op(3, 8'hC8, 8'h07, 0);
        do_op(3, 8'h5A, 8'h00, 0);
        do_op(8, 8'h81, 8'h08, 0);
        do_op(10, 8'h81, 8'h09, 0);
        do_op(10, 8'h80, 8'h03, 0);
        do_op(11, 8'h80, 8'h01, 0);
        do_op(13, 8'hAA, 8'h55, 0);
        do_op(2, 8'hFF, 8'hFF, 5);

        // backpressure then back-to-back accept right after release
        do_op(1, 8'h80, 8'h01, 0);
        @(negedge clk);
        opcode = 4'h2; a = 8'h0F; b = 8'h0F; in_valid = 1'b1;
        begin : bp
            int n;
            logic ok;
            logic [7:0] ys;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 1;
            while (out_valid !== 1'b1 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            chk("bp lat", n, 9);
            ys = y; ok = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                in_valid = 1'b1; opcode = 4'($urandom);
                a = 8'($urandom); b = 8'($urandom);
                @(posedge clk); #1;
                if (y !== ys || in_ready !== 1'b0 || out_valid !== 1'b1)
                    ok = 1'b0;
            end
            chk("bp stable", {31'b0, ok}, 1);
            chk("bp y", {24'b0, y}, 8'hE1);
            @(negedge clk);
            out_ready = 1'b1; opcode = 4'h0; a = 8'h03; b = 8'h04;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("bp idle", {30'b0, out_valid, in_ready}, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp next valid", {31'b0, out_valid}, 1);
            chk("bp next y", {24'b0, y}, 8'h07);
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end

        // reset during DIV iteration 4 aborts the operation
        @(negedge clk);
        opcode = 4'h3; a = 8'hC8; b = 8'h07; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort out_valid", {31'b0, out_valid}, 0);
        chk("abort in_ready", {31'b0, in_ready}, 1);
        chk("abort y", {24'b0, y}, 0);
        chk("abort y_hi", {24'b0, y_hi}, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 8'h03, 8'h04, 0);

        for (int k = 0; k < 40; k++) begin
            int op, av, bv;
            op = $urandom_range(0, 15);
            av = $urandom_range(0, 255);
            bv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10)
                                             : $urandom_range(0, 255);
            do_op(op, av, bv, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
